alu_chunked: RTL and testbench

//   Parametrised, multi-cycle integer ALU: WIDTH-bit add/sub/logic/compare,

---
 rtl/alu_chunked_if.sv | 29 ++
 rtl/alu_chunked.sv | 146 ++++++++++++++
 tb/tb_alu_chunked.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_chunked_if.sv
// Request/response bundle for the chunked ALU.
// master drives requests and accepts results; slave is the ALU.
interface alu_chunked_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result,
    input  zero, overflow, carry
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result,
    output zero, overflow, carry
  );
endinterface

// File: rtl/alu_chunked.sv
// Multi-cycle integer ALU, CHUNK bits per cycle.
// Operands shift right each cycle; the sum shifts in from the top.
module alu_chunked #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic         flush,
  alu_chunked_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_EQ   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ov_q;
  logic             co_q;

  logic             sub;
  logic             arith;
  logic             last;
  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   csum;
  logic [CHUNK-1:0] chunk;
  logic [WIDTH-1:0] s_full;
  logic             co;
  logic             ov;
  logic [WIDTH-1:0] res_fin;

  assign sub = (op_q == OP_SUB) || (op_q == OP_SLT) ||
               (op_q == OP_SLTU) || (op_q == OP_EQ);
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last = (cnt == CW'(NCHUNK - 1));

  always_comb begin
    bx = b_q[CHUNK-1:0] ^ {CHUNK{sub}};
    csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx} +
           {{CHUNK{1'b0}}, cy};
    co = csum[CHUNK];
    chunk = csum[CHUNK-1:0];
    case (op_q)
      OP_AND:  chunk = a_q[CHUNK-1:0] & b_q[CHUNK-1:0];
      OP_OR:   chunk = a_q[CHUNK-1:0] | b_q[CHUNK-1:0];
      OP_XOR:  chunk = a_q[CHUNK-1:0] ^ b_q[CHUNK-1:0];
      default: chunk = csum[CHUNK-1:0];
    endcase
    s_full = (WIDTH'(chunk) << (WIDTH - CHUNK)) | (s_q >> CHUNK);
    // sign of the effective B operand is the latched MSB, inverted on subtract
    ov = (a_msb == (b_msb ^ sub)) && (s_full[WIDTH-1] != a_msb);
    res_fin = s_full;
    case (op_q)
      OP_SLT:  res_fin = {{(WIDTH-1){1'b0}}, s_full[WIDTH-1] ^ ov};
      OP_SLTU: res_fin = {{(WIDTH-1){1'b0}}, ~co};
      OP_EQ:   res_fin = {{(WIDTH-1){1'b0}}, s_full == '0};
      default: res_fin = s_full;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      op_q     <= OP_ADD;
      cnt      <= '0;
      cy       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ov_q     <= 1'b0;
      co_q     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            s_q   <= '0;
            op_q  <= bus.op;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
            cy    <= (bus.op == OP_SUB) || (bus.op == OP_SLT) ||
                     (bus.op == OP_SLTU) || (bus.op == OP_EQ);
            state <= BUSY;
          end
        end
        BUSY: begin
          a_q <= a_q >> CHUNK;
          b_q <= b_q >> CHUNK;
          s_q <= s_full;
          cy  <= co;
          cnt <= cnt + CW'(1);
          if (last) begin
            cnt      <= '0;
            result_q <= res_fin;
            zero_q   <= (res_fin == '0);
            ov_q     <= arith & ov;
            co_q     <= arith & co;
            state    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ov_q;
  assign bus.carry     = co_q;
endmodule

// File: tb/tb_alu_chunked.sv
// Directed bench for alu_chunked: 32/8 and 4/4 instances.
// Expected values are hand-computed constants.
module tb_alu_chunked;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  always #5 clk = ~clk;

  alu_chunked_if #(.WIDTH(32)) bw ();
  alu_chunked_if #(.WIDTH(4))  bn ();

  alu_chunked #(.WIDTH(32), .CHUNK(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bw)
  );
  alu_chunked #(.WIDTH(4), .CHUNK(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bn)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue_w(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bw.op = op; bw.a = a; bw.b = b; bw.in_valid = 1'b1;
    step();
    bw.in_valid = 1'b0; bw.a = '0; bw.b = '0;
  endtask

  task automatic wait_w();
    lat = 0;
    while (!bw.out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic op_w(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z,
                      input logic v, input logic c);
    issue_w(op, a, b);
    wait_w();
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk({tag, "_res"}, bw.result, res);
    chk({tag, "_zvc"}, {29'd0, bw.zero, bw.overflow, bw.carry},
        {29'd0, z, v, c});
    bw.out_ready = 1'b1;
    step();
    bw.out_ready = 1'b0;
    chk({tag, "_rdy"}, {30'd0, bw.in_ready, bw.out_valid}, 32'd2);
  endtask

  task automatic op_n(input string tag, input logic [2:0] op,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] res, input logic z,
                      input logic v, input logic c);
    bn.op = op; bn.a = a; bn.b = b; bn.in_valid = 1'b1;
    step();
    bn.in_valid = 1'b0;
    lat = 0;
    while (!bn.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_res"}, {28'd0, bn.result}, {28'd0, res});
    chk({tag, "_zvc"}, {29'd0, bn.zero, bn.overflow, bn.carry},
        {29'd0, z, v, c});
    bn.out_ready = 1'b1;
    step();
    bn.out_ready = 1'b0;
  endtask

  initial begin
    bw.in_valid = 1'b0; bw.out_ready = 1'b0;
    bw.a = '0; bw.b = '0; bw.op = 3'd0;
    bn.in_valid = 1'b0; bn.out_ready = 1'b0;
    bn.a = '0; bn.b = '0; bn.op = 3'd0;
    step();
    step();
    chk("rst_out", {bw.result[30:0], bw.out_valid}, 32'd0);
    chk("rst_flags", {29'd0, bw.zero, bw.overflow, bw.carry}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, bw.in_ready}, 32'd1);

    op_w("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0);
    op_w("sub_eq", 3'd1, 32'd5, 32'd5, 32'd0, 1, 0, 1);
    op_w("sub_brw", 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0);
    op_w("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'd0, 1, 0, 1);
    op_w("slt", 3'd5, 32'hFFFF_FFFF, 32'h1, 32'd1, 0, 0, 0);
    op_w("sltu", 3'd6, 32'hFFFF_FFFF, 32'h1, 32'd0, 1, 0, 0);
    op_w("eq", 3'd7, 32'h1234, 32'h1234, 32'd1, 0, 0, 0);
    op_w("and", 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
         32'h00F0_00F0, 0, 0, 0);
    op_w("or", 3'd3, 32'hF000_0000, 32'h0000_000F,
         32'hF000_000F, 0, 0, 0);
    op_w("xor", 3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0, 1, 0, 0);

    issue_w(3'd0, 32'd1, 32'd2);
    wait_w();
    chk("bp_lat", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {bw.result[29:0], bw.out_valid, bw.in_ready},
          {30'd3, 1'b1, 1'b0});
    end
    bw.out_ready = 1'b1;
    step();
    bw.out_ready = 1'b0;
    chk("bp_rel", {30'd0, bw.in_ready, bw.out_valid}, 32'd2);

    issue_w(3'd0, 32'h11, 32'h22);
    step();
    flush = 1'b1;
    bw.in_valid = 1'b1; bw.op = 3'd1; bw.a = 32'd9; bw.b = 32'd4;
    step();
    flush = 1'b0;
    bw.in_valid = 1'b0;
    chk("fl_idle", {30'd0, bw.in_ready, bw.out_valid}, 32'd2);
    chk("fl_res", bw.result, 32'd3);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bw.out_valid) lat++;
    end
    chk("fl_noval", 32'(lat), 32'd0);

    issue_w(3'd0, 32'h7FFF_FFFF, 32'h1);
    wait_w();
    chk("rd_val", {31'd0, bw.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rd_out", {bw.result[30:0], bw.out_valid}, 32'd0);
    chk("rd_flags", {29'd0, bw.zero, bw.overflow, bw.carry}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rd_ready", {31'd0, bw.in_ready}, 32'd1);
    op_w("post_rst", 3'd1, 32'h100, 32'h1, 32'hFF, 0, 0, 1);

    op_n("n_add", 3'd0, 4'd7, 4'd1, 4'd8, 0, 1, 0);
    op_n("n_sub", 3'd1, 4'd3, 4'd5, 4'hE, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
